// File: rtl/adc_stim_pkg.sv
// Shared types and constants for the ADC stimulus generator: pattern modes,
// FSM states and the 16-bit LFSR seed/taps.
package adc_stim_pkg;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_NOISE  = 2'd3
    } stim_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } stim_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 16-bit Fibonacci LFSR for noisy-constant stimulus; reseeds on reset or
// seed_load, steps once per enable. Exposes only the low OUT_W bits.
module stim_lfsr
    import adc_stim_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    output logic [OUT_W-1:0] bits
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (seed_load) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign bits = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/adc_stim_gen.sv
// Multi-channel ADC stimulus generator: const/ramp/square/noisy patterns with
// gaps, bursts and abort. Noise source built only when STIM_NOISE_EN is defined.
module adc_stim_gen
    import adc_stim_pkg::*;
#(
    parameter int DW      = 14,
    parameter int NCH     = 2,
    parameter int GAP_W   = 8,
`ifdef STIM_NOISE_EN
    parameter int NOISE_B = 4,
`endif
    parameter int CNT_W   = 16
) (
    input  logic              adc_clk_i,
    input  logic              adc_rstn_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [1:0]        mode_i,
    input  logic [DW-1:0]     base_i,
    input  logic [DW-1:0]     step_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [GAP_W-1:0]  gap_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic [NCH*DW-1:0] dat_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  sample_cnt_o
);

    stim_state_e          state_q;
    stim_mode_e           mode_q;
    logic [DW-1:0]        base_q, step_q, ramp_q;
    logic [CNT_W-1:0]     period_q, count_q, sq_cnt_q;
    logic                 sq_hi_q;
    logic [GAP_W-1:0]     gap_q, gap_cnt_q;
    logic [DW-1:0]        ch_q [NCH];

    logic                 start_go, emit, last_sample;
    logic [CNT_W-1:0]     period_eff, cnt_inc;
    logic [DW-1:0]        new_val;

    assign start_go   = (state_q == ST_IDLE) && start_i && !stop_i;
    assign emit       = (state_q == ST_RUN) && !stop_i;
    assign period_eff = (period_q == '0) ? CNT_W'(1) : period_q;
    assign cnt_inc    = (sample_cnt_o == '1) ? sample_cnt_o : sample_cnt_o + CNT_W'(1);
    assign last_sample = (count_q != '0) && (cnt_inc == count_q);

`ifdef STIM_NOISE_EN
    logic [NOISE_B-1:0] noise_bits;
    logic [DW:0]        noisy_sum;
    logic [DW-1:0]      noisy_val;

    stim_lfsr #(.OUT_W(NOISE_B)) u_lfsr (
        .clk       (adc_clk_i),
        .rst_n     (adc_rstn_i),
        .en        (emit),
        .seed_load (start_go),
        .bits      (noise_bits)
    );

    // One guard bit catches overflow; clamp to the signed DW-bit extremes.
    always_comb begin
        noisy_sum = {base_q[DW-1], base_q}
                  + {{(DW+1-NOISE_B){noise_bits[NOISE_B-1]}}, noise_bits};
        if (noisy_sum[DW] != noisy_sum[DW-1])
            noisy_val = noisy_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            noisy_val = noisy_sum[DW-1:0];
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        new_val = base_q;
        case (mode_q)
            MODE_RAMP:   new_val = ramp_q;
            MODE_SQUARE: new_val = sq_hi_q ? base_q + step_q : base_q;
`ifdef STIM_NOISE_EN
            MODE_NOISE:  new_val = noisy_val;
`else
            MODE_NOISE:  new_val = base_q;
`endif
            default:     new_val = base_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_CONST;
            base_q       <= '0;
            step_q       <= '0;
            ramp_q       <= '0;
            period_q     <= '0;
            count_q      <= '0;
            sq_cnt_q     <= '0;
            sq_hi_q      <= 1'b0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            valid_o      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            sample_cnt_o <= '0;
            // NOTE: the delay line is a handful of flops, not a RAM, so it is reset.
            for (int k = 0; k < NCH; k++) ch_q[k] <= '0;
        end else begin
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        mode_q       <= stim_mode_e'(mode_i);
                        base_q       <= base_i;
                        step_q       <= step_i;
                        ramp_q       <= base_i;
                        period_q     <= period_i;
                        count_q      <= count_i;
                        gap_q        <= gap_i;
                        sq_cnt_q     <= '0;
                        sq_hi_q      <= 1'b0;
                        sample_cnt_o <= '0;
                        busy_o       <= 1'b1;
                        state_q      <= ST_RUN;
                        for (int k = 0; k < NCH; k++) ch_q[k] <= '0;
                    end
                end
                ST_RUN: begin
                    if (emit) begin
                        valid_o      <= 1'b1;
                        sample_cnt_o <= cnt_inc;
                        ch_q[0]      <= new_val;
                        for (int k = NCH-1; k > 0; k--) ch_q[k] <= ch_q[k-1];
                        ramp_q <= ramp_q + step_q;
                        if (sq_cnt_q == period_eff - CNT_W'(1)) begin
                            sq_cnt_q <= '0;
                            sq_hi_q  <= ~sq_hi_q;
                        end else begin
                            sq_cnt_q <= sq_cnt_q + CNT_W'(1);
                        end
                        if (last_sample) begin
                            state_q <= ST_DONE;
                        end else if (gap_q != '0) begin
                            gap_cnt_q <= gap_q - GAP_W'(1);
                            state_q   <= ST_GAP;
                        end
                    end else begin
                        busy_o  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (stop_i) begin
                        busy_o  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (gap_cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_pack
        assign dat_o[k*DW +: DW] = ch_q[k];
    end

endmodule

// File: tb/tb_adc_stim_gen.sv
// Scoreboard bench for adc_stim_gen: stimulus pushes hand-computed samples,
// a negedge monitor pops and compares on every valid_o.
module tb_adc_stim_gen;

    localparam int DW = 14;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0, stop_i = 1'b0;
    logic [1:0]        mode_i = '0;
    logic [DW-1:0]     base_i = '0, step_i = '0;
    logic [15:0]       period_i = '0, count_i = '0;
    logic [7:0]        gap_i = '0;
    logic [NCH*DW-1:0] dat_o;
    logic              valid_o, busy_o, done_o;
    logic [15:0]       sample_cnt_o;

    adc_stim_gen dut (
        .adc_clk_i    (clk),
        .adc_rstn_i   (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .base_i       (base_i),
        .step_i       (step_i),
        .period_i     (period_i),
        .gap_i        (gap_i),
        .count_i      (count_i),
        .dat_o        (dat_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sample_cnt_o (sample_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, last_valid_cyc = 0, n_done = 0;
    logic [NCH*DW-1:0] exp_q[$];
    int vcyc[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] ch0, input logic [DW-1:0] ch1);
        exp_q.push_back({ch1, ch0});
    endtask

    // Monitor: pops one expected sample per valid_o and checks done_o timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_valid: got dat 0x%0h with empty scoreboard", dat_o);
                end else begin
                    check("dat", 32'(dat_o), 32'(exp_q.pop_front()));
                end
                last_valid_cyc = cyc;
                vcyc.push_back(cyc);
            end
            if (done_o) begin
                n_done++;
                check("done_after_last", cyc, last_valid_cyc + 1);
            end
        end
    end

    task automatic start_burst(input logic [1:0] m, input logic [DW-1:0] b, input logic [DW-1:0] s,
                               input logic [15:0] per, input logic [7:0] g, input logic [15:0] c);
        @(posedge clk); #1;
        mode_i = m; base_i = b; step_i = s; period_i = per; gap_i = g; count_i = c;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy_o) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: busy_o still 1 after %0d cycles, required 0", name, t);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, busy_low;
        logic [15:0] lf;
        logic [DW-1:0] prev, nv;
        int sum;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dat", 32'(dat_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_cnt", 32'(sample_cnt_o), 0);
        rst_n = 1'b1;

        // Constant, count 4
        d0 = n_done;
        push(14'h123, 14'h000); push(14'h123, 14'h123);
        push(14'h123, 14'h123); push(14'h123, 14'h123);
        start_burst(2'd0, 14'h123, 14'h0, 16'd1, 8'd0, 16'd4);
        wait_idle("const");
        check("const_cnt", 32'(sample_cnt_o), 4);
        check("const_done", n_done - d0, 1);

        // Ramp across the positive-to-negative wrap
        d0 = n_done;
        push(14'h1FFE, 14'h0000); push(14'h1FFF, 14'h1FFE);
        push(14'h2000, 14'h1FFF); push(14'h2001, 14'h2000);
        start_burst(2'd1, 14'h1FFE, 14'h0001, 16'd1, 8'd0, 16'd4);
        wait_idle("ramp");
        check("ramp_done", n_done - d0, 1);

        // Square, period 2
        push(14'd0, 14'd0);     push(14'd0, 14'd0);
        push(14'd100, 14'd0);   push(14'd100, 14'd100);
        push(14'd0, 14'd100);   push(14'd0, 14'd0);
        push(14'd100, 14'd0);   push(14'd100, 14'd100);
        start_burst(2'd2, 14'd0, 14'd100, 16'd2, 8'd0, 16'd8);
        wait_idle("square");
        check("square_cnt", 32'(sample_cnt_o), 8);

        // Square with period 0 behaves as period 1
        push(14'd10, 14'd0);  push(14'd15, 14'd10);
        push(14'd10, 14'd15); push(14'd15, 14'd10);
        start_burst(2'd2, 14'd10, 14'd5, 16'd0, 8'd0, 16'd4);
        wait_idle("period0");

        // Gap 3, count 3; a start pulse mid-burst must be ignored
        d0 = n_done;
        vcyc.delete();
        push(14'h055, 14'h000); push(14'h055, 14'h055); push(14'h055, 14'h055);
        start_burst(2'd0, 14'h055, 14'h0, 16'd1, 8'd3, 16'd3);
        busy_low = 0;
        for (int i = 0; i < 40 && !done_o; i++) begin
            @(negedge clk);
            if (!busy_o && !done_o) busy_low++;
            if (i == 2) begin
                base_i = 14'h077;
                start_i = 1'b1;
                @(posedge clk); #1;
                start_i = 1'b0;
            end
        end
        wait_idle("gap");
        check("gap_busy_low_cycles", busy_low, 0);
        check("gap_valid_count", vcyc.size(), 3);
        if (vcyc.size() == 3) begin
            check("gap_spacing_1", vcyc[1] - vcyc[0], 4);
            check("gap_spacing_2", vcyc[2] - vcyc[1], 4);
        end
        check("gap_cnt", 32'(sample_cnt_o), 3);
        check("gap_done", n_done - d0, 1);

        // Continuous ramp aborted after the 5th sample
        d0 = n_done;
        push(14'd0, 14'd0); push(14'd2, 14'd0); push(14'd4, 14'd2);
        push(14'd6, 14'd4); push(14'd8, 14'd6);
        start_burst(2'd1, 14'd0, 14'd2, 16'd1, 8'd0, 16'd0);
        repeat (5) @(posedge clk);
        #1 stop_i = 1'b1;
        @(posedge clk); #1;
        stop_i = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_valid", 32'(valid_o), 0);
        repeat (4) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_cnt", 32'(sample_cnt_o), 5);
        check("abort_dat_held", 32'(dat_o), {4'h0, 14'd6, 14'd8});

        // start_i with stop_i in IDLE: no burst
        @(posedge clk); #1;
        start_i = 1'b1; stop_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; stop_i = 1'b0;
        @(negedge clk);
        check("start_stop_busy", 32'(busy_o), 0);
        check("start_stop_cnt", 32'(sample_cnt_o), 5);

        // Mode 3 from the top of the positive range
`ifdef STIM_NOISE_EN
        lf = 16'hACE1;
        prev = '0;
        for (int i = 0; i < 3; i++) begin
            sum = 8191 + ((int'(lf[3:0]) > 7) ? int'(lf[3:0]) - 16 : int'(lf[3:0]));
            if (sum > 8191) sum = 8191;
            nv = DW'(sum);
            push(nv, prev);
            prev = nv;
            lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
        end
`else
        lf = '0; prev = '0; nv = '0; sum = 0;
        push(14'h1FFF, 14'h0000); push(14'h1FFF, 14'h1FFF); push(14'h1FFF, 14'h1FFF);
`endif
        start_burst(2'd3, 14'h1FFF, 14'h0, 16'd1, 8'd0, 16'd3);
        wait_idle("noise");
        check("noise_cnt", 32'(sample_cnt_o), 3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
